ir_key_dec: RTL and testbench
=============================

// Module: ir_key_dec
// PURPOSE
//  - Downstream of the NEC IR receiver. Consumes each completed 32-bit frame and checks address and command complements.
//  - Filters frames by the configured device address, then buffers accepted key codes in a small FIFO.
//  - Hands keys to the display/control logic over a valid/ready interface and counts rejected frames.
// PARAMETERS
//  DEV_ADDR      8'h00   accepted NEC address; frames with another address are dropped (not counted as errors)
//  FIFO_DEPTH    4       key FIFO entries, power of two, 2..16
//  DEDUP_CYC     5400000 de-dup window in clk cycles (108 ms @ 50 MHz); used only with IR_DEDUP_EN
// PORTS
//  clk           in   1   system clock, 50 MHz
//  rst_n         in   1   synchronous active-low reset
//  i_frame_data  in   32  {addr[31:24], ~addr[23:16], cmd[15:8], ~cmd[7:0]}
//  i_frame_vld   in   1   one-cycle strobe: i_frame_data holds a new frame
//  o_key         out  8   command byte at FIFO head
//  o_key_vld     out  1   FIFO not empty
//  i_key_rdy     in   1   consumer accepts o_key when o_key_vld & i_key_rdy
//  o_err_cnt     out  8   count of complement-check failures, saturates at 8'hFF
//  o_ovf         out  1   one-cycle pulse: an accepted key was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (sync, rst_n==0 at a clk edge):
//    - FSM returns to IDLE; FIFO is emptied.
//    - Outputs: o_key=0, o_key_vld=0, o_err_cnt=0, o_ovf=0.
//    - A frame in flight is discarded.
//  - FSM states: IDLE, CHECK, PUSH.
//    - IDLE: on i_frame_vld, latch i_frame_data and go to CHECK. Otherwise stay.
//    - CHECK: compute addr_ok = (b31:24 == ~b23:16) and cmd_ok = (b15:8 == ~b7:0).
//      - !addr_ok | !cmd_ok: o_err_cnt += 1 (saturating), go to IDLE.
//      - Both checks pass but addr != DEV_ADDR: go to IDLE silently.
//      - Otherwise go to PUSH.
//    - PUSH: write cmd into the FIFO if not full, else pulse o_ovf. Always go to IDLE.
//  - i_frame_vld is ignored while not in IDLE. The receiver spaces frames by at least 10 ms, so no drop is expected in normal use.
//  - Latency: strobe at cycle N -> CHECK at N+1 -> FIFO write at N+2 -> o_key_vld=1 and o_key valid at N+3 (FIFO was empty).
//  - FIFO:
//    - Registered head; pointers of width $clog2(FIFO_DEPTH)+1 that wrap naturally.
//    - Full when the pointers differ only in the MSB.
//    - Pop and push in the same cycle are both performed: occupancy unchanged, order preserved.
//    - Push while full: no write, o_ovf=1 for 1 cycle, contents unchanged, even if a pop happens in the same cycle.
//  - o_key holds its value while o_key_vld=0. It changes only on a pop or when the first entry is written into an empty FIFO.
// CONFIGURATION
//  IR_DEDUP_EN defined:
//   - A frame whose cmd equals the last pushed cmd, arriving < DEDUP_CYC cycles after that push, is dropped in PUSH.
//   - Such a drop counts neither as an error nor as an overflow.
//   - The timer restarts at every push and saturates; reset clears the last-cmd valid flag.
//  IR_DEDUP_EN undefined: every valid matching frame is pushed; no timer logic exists.
// STRUCTURE
//  - Shared package ir_pkg:
//    - state encoding (IDLE/CHECK/PUSH, 2 bits)
//    - NEC field index constants (ADDR_MSB..CMDN_LSB)
//    - the 50 MHz DEDUP_CYC default constant
//  - One sub-module: ir_key_fifo (sync FIFO with valid/ready read, full flag, drop-on-full write).
//  - The FSM, checks and error counter stay in ir_key_dec.
// TESTING
//  1. Reset; strobe 32'h00FF_16E9 (addr 00, cmd 16) -> o_key_vld=1 at N+3, o_key=8'h16; rdy=1 -> o_key_vld=0 next cycle.
//  2. Strobe 32'h00FF_16E8 (bad cmd complement) -> no key, o_err_cnt=1; 300 bad frames -> o_err_cnt=8'hFF.
//  3. DEV_ADDR=00, strobe 32'h01FE_16E9 -> no key, o_err_cnt unchanged.
//  4. rdy=0, push 5 distinct cmds 01..05 -> o_ovf pulses once on 05; then rdy=1 -> pops 01,02,03,04 in order.
//  5. FIFO full, strobe frame in the cycle a pop occurs -> still dropped, o_ovf=1; rst_n=0 mid-CHECK -> o_key_vld=0, no later key.
//  6. IR_DEDUP_EN, DEDUP_CYC=100: cmd 16 twice 50 cycles apart -> one key; a third 150 cycles after the first push -> second key.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR key decoder: FSM encoding, frame field
// positions and the default de-dup window.
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      PUSH  = 2'd2
   } state_t;

   // Frame layout: {addr, ~addr, cmd, ~cmd}
   localparam int ADDR_MSB  = 31;
   localparam int ADDR_LSB  = 24;
   localparam int ADDRN_MSB = 23;
   localparam int ADDRN_LSB = 16;
   localparam int CMD_MSB   = 15;
   localparam int CMD_LSB   = 8;
   localparam int CMDN_MSB  = 7;
   localparam int CMDN_LSB  = 0;

   // 108 ms repeat window at a 50 MHz clock
   localparam int DEDUP_CYC_DFLT = 5400000;

endpackage

// File: rtl/ir_key_fifo.sv
// Synchronous key FIFO with a registered head, valid/ready read side and
// drop-on-full write side that flags the dropped write on ovf.
module ir_key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             vld,
   input  logic             rdy,
   output logic             full,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      rd_nxt;
   logic             empty;
   logic             wr_en;
   logic             rd_en;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign vld    = !empty;
   assign rd_en  = vld && rdy;
   assign wr_en  = push && !full;
   assign ovf    = push && full;
   assign rd_nxt = rd_ptr + (AW+1)'(1);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   // Head tracks the oldest entry; a write that lands behind a lone popped
   // entry is forwarded straight into the head.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_nxt;
         end
         if (empty && wr_en) begin
            head <= push_data;
         end else if (rd_en) begin
            if (rd_nxt != wr_ptr) begin
               head <= mem[rd_nxt[AW-1:0]];
            end else if (wr_en) begin
               head <= push_data;
            end
         end
      end
   end

endmodule

// File: rtl/ir_key_dec.sv
// NEC frame checker/filter feeding a key FIFO. Optional repeat suppression
// is compiled in with the IR_DEDUP_EN macro.
module ir_key_dec
   import ir_pkg::*;
#(
   parameter logic [7:0] DEV_ADDR   = 8'h00,
   parameter int         FIFO_DEPTH = 4,
   parameter int         DEDUP_CYC  = DEDUP_CYC_DFLT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_frame_data,
   input  logic        i_frame_vld,
   output logic [7:0]  o_key,
   output logic        o_key_vld,
   input  logic        i_key_rdy,
   output logic [7:0]  o_err_cnt,
   output logic        o_ovf
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] frame_p1;
   logic [7:0]  addr;
   logic [7:0]  cmd;
   logic        addr_ok;
   logic        cmd_ok;
   logic        push_req;
   logic        dup_hit;
   logic [7:0]  err_cnt;
   logic        fifo_full;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign addr    = frame_p1[ADDR_MSB:ADDR_LSB];
   assign cmd     = frame_p1[CMD_MSB:CMD_LSB];
   assign addr_ok = (addr == ~frame_p1[ADDRN_MSB:ADDRN_LSB]);
   assign cmd_ok  = (cmd == ~frame_p1[CMDN_MSB:CMDN_LSB]);

   // Capture stage: frame latched only when the FSM can take it
   always_ff @(posedge clk) begin
      if (state == IDLE && i_frame_vld) begin
         frame_p1 <= i_frame_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         err_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CHECK && !(addr_ok && cmd_ok)) begin
            err_cnt <= sat_inc8(err_cnt);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      case (state)
         IDLE: begin
            if (i_frame_vld) begin
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (!(addr_ok && cmd_ok) || addr != DEV_ADDR) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = PUSH;
            end
         end
         PUSH: begin
            push_req  = !dup_hit;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef IR_DEDUP_EN
   localparam int TW = $clog2(DEDUP_CYC + 1);

   logic [TW-1:0] dup_tmr;
   logic [7:0]    last_cmd;
   logic          last_vld;

   assign dup_hit = last_vld && (cmd == last_cmd) && (dup_tmr < TW'(DEDUP_CYC));

   // Timer counts up from each push and parks at the window length
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_vld <= 1'b0;
         dup_tmr  <= '0;
      end else if (push_req) begin
         last_vld <= 1'b1;
         dup_tmr  <= '0;
      end else if (dup_tmr < TW'(DEDUP_CYC)) begin
         dup_tmr <= dup_tmr + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_req) begin
         last_cmd <= cmd;
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   ir_key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_req),
      .push_data (cmd),
      .head      (o_key),
      .vld       (o_key_vld),
      .rdy       (i_key_rdy),
      .full      (fifo_full),
      .ovf       (o_ovf)
   );

   assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_ir_key_dec.sv
// Directed bench for ir_key_dec: latency, complement errors, address filter,
// FIFO order/overflow, reset in flight and repeat handling.
module tb_ir_key_dec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_frame_data;
   logic        i_frame_vld;
   logic [7:0]  o_key;
   logic        o_key_vld;
   logic        i_key_rdy;
   logic [7:0]  o_err_cnt;
   logic        o_ovf;

   int n_cmp = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   ir_key_dec #(
      .DEV_ADDR   (8'h00),
      .FIFO_DEPTH (4),
      .DEDUP_CYC  (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_data (i_frame_data),
      .i_frame_vld  (i_frame_vld),
      .o_key        (o_key),
      .o_key_vld    (o_key_vld),
      .i_key_rdy    (i_key_rdy),
      .o_err_cnt    (o_err_cnt),
      .o_ovf        (o_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
      return {a, ~a, c, ~c};
   endfunction

   // Drive a one-cycle strobe; returns with the DUT in CHECK
   task automatic strobe(input logic [31:0] f);
      i_frame_data = f;
      i_frame_vld  = 1'b1;
      tick();
      i_frame_vld  = 1'b0;
   endtask

   // Good frame, full walk back to IDLE, ovf sampled during PUSH
   task automatic push_key(input logic [7:0] c, input logic exp_ovf, input string tag);
      strobe(nec(8'h00, c));
      tick();
      check(tag, {31'd0, o_ovf}, {31'd0, exp_ovf});
      tick();
   endtask

   initial begin
      int pops;
      int exp_pops;

      rst_n        = 1'b0;
      i_frame_data = '0;
      i_frame_vld  = 1'b0;
      i_key_rdy    = 1'b0;
      tick();
      tick();
      check("rst_key",     {24'd0, o_key},     32'h0);
      check("rst_vld",     {31'd0, o_key_vld}, 32'h0);
      check("rst_err",     {24'd0, o_err_cnt}, 32'h0);
      check("rst_ovf",     {31'd0, o_ovf},     32'h0);
      rst_n = 1'b1;
      tick();

      // Basic key with N+3 latency
      strobe(32'h00FF_16E9);
      tick();
      check("lat_n2_vld",  {31'd0, o_key_vld}, 32'h0);
      tick();
      check("lat_n3_vld",  {31'd0, o_key_vld}, 32'h1);
      check("lat_n3_key",  {24'd0, o_key},     32'h16);
      i_key_rdy = 1'b1;
      tick();
      i_key_rdy = 1'b0;
      check("pop_vld",     {31'd0, o_key_vld}, 32'h0);
      check("pop_hold",    {24'd0, o_key},     32'h16);

      // Complement errors and saturation
      strobe(32'h00FF_16E8);
      tick();
      check("bad_err1",    {24'd0, o_err_cnt}, 32'h1);
      tick();
      check("bad_nokey",   {31'd0, o_key_vld}, 32'h0);
      for (int i = 0; i < 300; i++) begin
         strobe(32'h00FF_16E8);
         tick();
         tick();
      end
      check("err_sat",     {24'd0, o_err_cnt}, 32'hFF);

      // Foreign address: silently dropped
      strobe(32'h01FE_16E9);
      tick();
      tick();
      tick();
      check("addr_nokey",  {31'd0, o_key_vld}, 32'h0);
      check("addr_err",    {24'd0, o_err_cnt}, 32'hFF);

      // Fill beyond depth with consumer stalled
      push_key(8'h01, 1'b0, "ovf_k1");
      push_key(8'h02, 1'b0, "ovf_k2");
      push_key(8'h03, 1'b0, "ovf_k3");
      push_key(8'h04, 1'b0, "ovf_k4");
      push_key(8'h05, 1'b1, "ovf_k5");
      check("ovf_once",    {31'd0, o_ovf},     32'h0);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("order_vld%0d", k), {31'd0, o_key_vld}, 32'h1);
         check($sformatf("order_key%0d", k), {24'd0, o_key},     32'(k));
         i_key_rdy = 1'b1;
         tick();
      end
      i_key_rdy = 1'b0;
      check("drain_vld",   {31'd0, o_key_vld}, 32'h0);
      check("drain_hold",  {24'd0, o_key},     32'h04);

      // Full FIFO, push coincides with a pop: still dropped
      push_key(8'h21, 1'b0, "fill_k1");
      check("first_wr",    {24'd0, o_key},     32'h21);
      push_key(8'h22, 1'b0, "fill_k2");
      push_key(8'h23, 1'b0, "fill_k3");
      push_key(8'h24, 1'b0, "fill_k4");
      strobe(nec(8'h00, 8'h25));
      tick();
      i_key_rdy = 1'b1;
      check("popfull_ovf", {31'd0, o_ovf},     32'h1);
      tick();
      i_key_rdy = 1'b0;
      check("popfull_key", {24'd0, o_key},     32'h22);
      check("popfull_vld", {31'd0, o_key_vld}, 32'h1);

      // Reset while a frame sits in CHECK
      strobe(nec(8'h00, 8'h30));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rstmid_vld",  {31'd0, o_key_vld}, 32'h0);
      check("rstmid_key",  {24'd0, o_key},     32'h0);
      check("rstmid_err",  {24'd0, o_err_cnt}, 32'h0);
      for (int i = 0; i < 5; i++) tick();
      check("rstmid_late", {31'd0, o_key_vld}, 32'h0);

      // Repeat of the same command: 50 cycles apart, then 150 after first push
      strobe(nec(8'h00, 8'h16));
      for (int i = 0; i < 49; i++) tick();
      strobe(nec(8'h00, 8'h16));
      for (int i = 0; i < 101; i++) tick();
      strobe(nec(8'h00, 8'h16));
      tick();
      tick();
      tick();
`ifdef IR_DEDUP_EN
      exp_pops = 2;
`else
      exp_pops = 3;
`endif
      pops = 0;
      i_key_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (o_key_vld) begin
            check($sformatf("dup_key%0d", pops), {24'd0, o_key}, 32'h16);
            pops++;
         end
         tick();
      end
      i_key_rdy = 1'b0;
      check("dup_count",   32'(pops),          32'(exp_pops));
      check("dup_noerr",   {24'd0, o_err_cnt}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
